// File: rtl/up_packet_interface.sv
// up_packet_interface: uP-side framed byte interface. It turns a command/register/data
// packet into a single-cycle register-bus write or read, then replies with a status byte
// and, for good reads, the read data. Every transfer uses a four-phase handshake.
module up_packet_interface #(
    parameter int unsigned DATA_BYTES    = 4,
    parameter int unsigned NOS_REGISTERS = 64,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned READ_TIMEOUT  = 255
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    uP_start,
    input  logic                    uP_handshake_1,
    input  logic [7:0]              uP_data_out,
    output logic                    uP_handshake_2,
    output logic                    uP_ack,
    output logic [7:0]              uP_data_in,
    output logic [7:0]              reg_addr,
    output logic [DATA_BYTES*8-1:0] reg_wdata,
    output logic                    reg_write,
    output logic                    reg_read,
    input  logic [DATA_BYTES*8-1:0] reg_rdata,
    input  logic                    reg_ready
);

    localparam int unsigned DW    = DATA_BYTES * 8;
    localparam int unsigned CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned TMR_W = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(READ_TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE  = 8'd0;
    localparam logic [7:0] CMD_READ   = 8'd1;
    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CMD = 8'h01;
    localparam logic [7:0] ST_BAD_REG = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    // Handshake sub-phase. Receive uses WAIT/HOLD; send uses WAIT/HOLD/RELEASE.
    localparam logic [1:0] PH_WAIT    = 2'd0;
    localparam logic [1:0] PH_HOLD    = 2'd1;
    localparam logic [1:0] PH_RELEASE = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_REG,
        S_GET_DATA,
        S_EXECUTE,
        S_WAIT_READ,
        S_SEND_STATUS,
        S_SEND_DATA,
        S_ACK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] start_sync_q, start_sync_d;
    logic [SYNC_STAGES-1:0] hs1_sync_q, hs1_sync_d;
    logic                   start_prev_q, start_prev_d;
    logic [1:0]             phase_q, phase_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             status_q, status_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   hs2_q, hs2_d;
    logic                   ack_q, ack_d;
    logic [7:0]             din_q, din_d;
    logic [7:0]             addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic                   read_q, read_d;

    logic start_s, hs1_s;
    logic abort_c, rx_latch_c, rx_done_c, tx_hi_c, tx_done_c;
    logic cmd_known_c, reg_ok_c, last_byte_c;

    // Synchroniser shift chains for the asynchronous uP control lines
    always_comb begin
        start_sync_d = {start_sync_q[SYNC_STAGES-2:0], uP_start};
        hs1_sync_d   = {hs1_sync_q[SYNC_STAGES-2:0], uP_handshake_1};
        start_prev_d = start_s;
    end

    // Shared decode of handshake progress and packet properties
    always_comb begin
        start_s     = start_sync_q[SYNC_STAGES-1];
        hs1_s       = hs1_sync_q[SYNC_STAGES-1];
        abort_c     = !start_s && (state_q != S_IDLE) && (state_q != S_ACK);
        rx_latch_c  = (phase_q == PH_WAIT) && hs1_s;
        rx_done_c   = (phase_q == PH_HOLD) && !hs1_s;
        tx_hi_c     = (phase_q == PH_HOLD) && hs1_s;
        tx_done_c   = (phase_q == PH_RELEASE) && !hs1_s;
        cmd_known_c = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
        reg_ok_c    = ({1'b0, addr_q} < 9'(NOS_REGISTERS));
        last_byte_c = (cnt_q == LAST_BYTE);
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped frame outside IDLE/ACK aborts straight to IDLE
    always_comb begin
        state_d = state_q;
        if (abort_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:        if (start_s && !start_prev_q) state_d = S_GET_CMD;
                S_GET_CMD:     if (rx_done_c) state_d = cmd_known_c ? S_GET_REG : S_SEND_STATUS;
                S_GET_REG:     if (rx_done_c) state_d = (cmd_q == CMD_WRITE) ? S_GET_DATA : S_EXECUTE;
                S_GET_DATA:    if (rx_done_c && last_byte_c) state_d = S_EXECUTE;
                S_EXECUTE:     state_d = ((cmd_q == CMD_READ) && reg_ok_c) ? S_WAIT_READ : S_SEND_STATUS;
                S_WAIT_READ:   if (reg_ready || (tmr_q == TMR_LAST)) state_d = S_SEND_STATUS;
                S_SEND_STATUS: if (tx_done_c)
                                   state_d = ((cmd_q == CMD_READ) && (status_q == ST_OK)) ? S_SEND_DATA : S_ACK;
                S_SEND_DATA:   if (tx_done_c && last_byte_c) state_d = S_ACK;
                S_ACK:         if (!start_s) state_d = S_IDLE;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        cmd_d    = cmd_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        hs2_d    = hs2_q;
        ack_d    = 1'b0;
        din_d    = din_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = 1'b0;
        read_d   = 1'b0;
        if (abort_c) begin
            hs2_d   = 1'b0;
            phase_d = PH_WAIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hs2_d   = 1'b0;
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end
                S_GET_CMD, S_GET_REG, S_GET_DATA: begin
                    if (rx_latch_c) begin
                        hs2_d   = 1'b1;
                        phase_d = PH_HOLD;
                        if (state_q == S_GET_CMD) cmd_d = uP_data_out;
                        else if (state_q == S_GET_REG) addr_d = uP_data_out;
                        else wdata_d[{cnt_q, 3'b000} +: 8] = uP_data_out;
                    end else if (rx_done_c) begin
                        hs2_d   = 1'b0;
                        phase_d = PH_WAIT;
                        if (state_q == S_GET_CMD && !cmd_known_c) status_d = ST_BAD_CMD;
                        if (state_q == S_GET_REG) cnt_d = '0;
                        if (state_q == S_GET_DATA && !last_byte_c) cnt_d = cnt_q + 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (!reg_ok_c) begin
                        status_d = ST_BAD_REG;
                    end else if (cmd_q == CMD_WRITE) begin
                        write_d  = 1'b1;
                        status_d = ST_OK;
                    end else begin
                        read_d = 1'b1;
                        tmr_d  = '0;
                    end
                end
                S_WAIT_READ: begin
                    if (reg_ready) begin
                        rdata_d  = reg_rdata;
                        status_d = ST_OK;
                    end else if (tmr_q == TMR_LAST) begin
                        rdata_d  = '0;
                        status_d = ST_TIMEOUT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                S_SEND_STATUS, S_SEND_DATA: begin
                    if (phase_q == PH_WAIT) begin
                        din_d   = (state_q == S_SEND_STATUS) ? status_q : rdata_q[{cnt_q, 3'b000} +: 8];
                        hs2_d   = 1'b1;
                        phase_d = PH_HOLD;
                    end else if (tx_hi_c) begin
                        hs2_d   = 1'b0;
                        phase_d = PH_RELEASE;
                    end else if (tx_done_c) begin
                        phase_d = PH_WAIT;
                        if (state_q == S_SEND_STATUS) cnt_d = '0;
                        else if (!last_byte_c) cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
                    ack_d = start_s;
                end
                default: begin
                    hs2_d   = 1'b0;
                    phase_d = PH_WAIT;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            start_sync_q <= '0;
            hs1_sync_q   <= '0;
            start_prev_q <= 1'b0;
            phase_q      <= PH_WAIT;
            cnt_q        <= '0;
            tmr_q        <= '0;
            cmd_q        <= '0;
            status_q     <= '0;
            rdata_q      <= '0;
            hs2_q        <= 1'b0;
            ack_q        <= 1'b0;
            din_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
        end else begin
            start_sync_q <= start_sync_d;
            hs1_sync_q   <= hs1_sync_d;
            start_prev_q <= start_prev_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            cmd_q        <= cmd_d;
            status_q     <= status_d;
            rdata_q      <= rdata_d;
            hs2_q        <= hs2_d;
            ack_q        <= ack_d;
            din_q        <= din_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            read_q       <= read_d;
        end
    end

    assign uP_handshake_2 = hs2_q;
    assign uP_ack         = ack_q;
    assign uP_data_in     = din_q;
    assign reg_addr       = addr_q;
    assign reg_wdata      = wdata_q;
    assign reg_write      = write_q;
    assign reg_read       = read_q;

endmodule

// File: tb/tb_up_packet_interface.sv
// Bench for up_packet_interface: two instances (4-byte/2-stage and 2-byte/3-stage) share
// one uP driver and register-bus responder, selected by sel. A packet-level model predicts
// reply bytes and register strobes; a monitor checks strobes every cycle.
module tb_up_packet_interface;

    localparam int DB_A = 4;
    localparam int SS_A = 2;
    localparam int DB_B = 2;
    localparam int SS_B = 3;
    localparam int NOS  = 64;
    localparam int RTO  = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        up_start, up_hs1, sel, rdy;
    logic [7:0]  up_dout;
    logic [31:0] rdata;

    logic a_start, a_hs1, a_rdy, b_start, b_hs1, b_rdy;
    assign a_start = up_start & ~sel;
    assign a_hs1   = up_hs1 & ~sel;
    assign a_rdy   = rdy & ~sel;
    assign b_start = up_start & sel;
    assign b_hs1   = up_hs1 & sel;
    assign b_rdy   = rdy & sel;

    logic        a_hs2, a_ack, a_wr, a_rd, b_hs2, b_ack, b_wr, b_rd;
    logic [7:0]  a_din, a_addr, b_din, b_addr;
    logic [31:0] a_wdata;
    logic [15:0] b_wdata;

    up_packet_interface #(.DATA_BYTES(DB_A), .NOS_REGISTERS(NOS), .SYNC_STAGES(SS_A), .READ_TIMEOUT(RTO)) dut_a (
        .CLOCK_50(clk), .reset(rst_n), .uP_start(a_start), .uP_handshake_1(a_hs1), .uP_data_out(up_dout),
        .uP_handshake_2(a_hs2), .uP_ack(a_ack), .uP_data_in(a_din), .reg_addr(a_addr), .reg_wdata(a_wdata),
        .reg_write(a_wr), .reg_read(a_rd), .reg_rdata(rdata), .reg_ready(a_rdy)
    );

    up_packet_interface #(.DATA_BYTES(DB_B), .NOS_REGISTERS(NOS), .SYNC_STAGES(SS_B), .READ_TIMEOUT(RTO)) dut_b (
        .CLOCK_50(clk), .reset(rst_n), .uP_start(b_start), .uP_handshake_1(b_hs1), .uP_data_out(up_dout),
        .uP_handshake_2(b_hs2), .uP_ack(b_ack), .uP_data_in(b_din), .reg_addr(b_addr), .reg_wdata(b_wdata),
        .reg_write(b_wr), .reg_read(b_rd), .reg_rdata(rdata[15:0]), .reg_ready(b_rdy)
    );

    logic        hs2, ack, wr, rd;
    logic [7:0]  din, addr;
    logic [31:0] wdata;
    assign hs2   = sel ? b_hs2 : a_hs2;
    assign ack   = sel ? b_ack : a_ack;
    assign wr    = sel ? b_wr : a_wr;
    assign rd    = sel ? b_rd : a_rd;
    assign din   = sel ? b_din : a_din;
    assign addr  = sel ? b_addr : a_addr;
    assign wdata = sel ? {16'h0, b_wdata} : a_wdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  pkt[$];
    logic [7:0]  exp_reply[$];
    logic [7:0]  got[$];
    bit          exp_wr, exp_rd, tmo_armed;
    logic [7:0]  exp_addr, last_addr;
    logic [31:0] exp_wdata, last_wdata, rd_value;
    int          wr_seen, rd_seen, rd_delay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t sel=%0d)", name, act, req, $time, sel);
        end
    endtask

    function automatic int db_of();
        return sel ? DB_B : DB_A;
    endfunction

    function automatic int ss_of();
        return sel ? SS_B : SS_A;
    endfunction

    // Packet-level model: what the block must reply and which strobe it must issue
    task automatic model(input int delay, input logic [31:0] rv);
        int db;
        db = db_of();
        exp_reply.delete();
        exp_wr = 1'b0; exp_rd = 1'b0; exp_addr = '0; exp_wdata = '0;
        if (pkt[0] > 8'd1) begin
            exp_reply.push_back(8'h01);
        end else if (int'(pkt[1]) >= NOS) begin
            exp_addr = pkt[1];
            exp_reply.push_back(8'h02);
        end else if (pkt[0] == 8'd0) begin
            exp_wr = 1'b1; exp_addr = pkt[1];
            for (int k = 0; k < db; k++) exp_wdata[8*k +: 8] = pkt[2+k];
            exp_reply.push_back(8'h00);
        end else begin
            exp_rd = 1'b1; exp_addr = pkt[1];
            if (delay >= 0 && delay < RTO) begin
                exp_reply.push_back(8'h00);
                for (int k = 0; k < db; k++) exp_reply.push_back(rv[8*k +: 8]);
            end else begin
                exp_reply.push_back(8'h03);
            end
        end
    endtask

    task automatic build(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5);
        logic [7:0] t [6];
        t = '{b0, b1, b2, b3, b4, b5};
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(t[i]);
    endtask

    task automatic expect_got(input int n, input logic [7:0] l0, l1, l2, l3, l4);
        logic [7:0] t [5];
        t = '{l0, l1, l2, l3, l4};
        check("lit_reply_len", 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) check("lit_reply_byte", 32'(got[i]), 32'(t[i]));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        up_dout = b;
        up_hs1  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (hs2 !== 1'b1 && n < 100);
        check("rx_hs2_latency", 32'(n), 32'(ss_of() + 1));
        up_hs1 = 1'b0;
        n = 0;
        while (hs2 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rx_hs2_release", 32'(hs2), 32'd0);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        n = 0;
        while (hs2 !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tx_hs2_rise", 32'(hs2), 32'd1);
        b = din;
        up_hs1 = 1'b1;
        n = 0;
        while (hs2 !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx_hs2_fall", 32'(hs2), 32'd0);
        up_hs1 = 1'b0;
    endtask

    task automatic run_packet(input int delay, input logic [31:0] rv);
        logic [7:0] b;
        int n;
        model(delay, rv);
        rd_delay = delay; rd_value = rv;
        wr_seen = 0; rd_seen = 0;
        got.delete();
        tmo_armed = exp_rd && (delay < 0);
        up_start = 1'b1;
        repeat (ss_of() + 2) @(negedge clk);
        foreach (pkt[i]) send_byte(pkt[i]);
        foreach (exp_reply[i]) begin
            recv_byte(b);
            got.push_back(b);
            check("reply_byte", 32'(b), 32'(exp_reply[i]));
        end
        n = 0;
        while (ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_high", 32'(ack), 32'd1);
        check("write_count", 32'(wr_seen), 32'(exp_wr));
        check("read_count", 32'(rd_seen), 32'(exp_rd));
        check("hs2_low_in_ack", 32'(hs2), 32'd0);
        up_start = 1'b0;
        n = 0;
        while (ack !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_low", 32'(ack), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Register-bus responder: returns rd_value rd_delay cycles after reg_read (never if negative)
    initial begin : responder
        rdy = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rd === 1'b1 && rd_delay >= 0) begin
                repeat (rd_delay) @(negedge clk);
                rdata = rd_value;
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
                rdata = $urandom();
            end
        end
    end

    // Per-cycle strobe checks against the model
    initial begin : monitor
        int cyc, rd_cyc;
        logic wr_prev, rd_prev, hs2_prev;
        cyc = 0; rd_cyc = 0; wr_prev = 1'b0; rd_prev = 1'b0; hs2_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n === 1'b1) begin
                if (wr === 1'b1 || rd === 1'b1) check("strobe_exclusive", 32'(wr & rd), 32'd0);
                if (wr === 1'b1) begin
                    wr_seen++;
                    check("write_expected", 32'(exp_wr), 32'd1);
                    check("write_single_cycle", 32'(wr_prev), 32'd0);
                    check("write_addr", 32'(addr), 32'(exp_addr));
                    check("write_data", wdata, exp_wdata);
                    last_addr = addr;
                    last_wdata = wdata;
                end
                if (rd === 1'b1) begin
                    rd_seen++;
                    rd_cyc = cyc;
                    check("read_expected", 32'(exp_rd), 32'd1);
                    check("read_single_cycle", 32'(rd_prev), 32'd0);
                    check("read_addr", 32'(addr), 32'(exp_addr));
                end
                if (hs2 === 1'b1 && hs2_prev === 1'b0 && tmo_armed && rd_seen > 0) begin
                    check("timeout_latency", 32'(cyc - rd_cyc), 32'(RTO + 1));
                    tmo_armed = 1'b0;
                end
            end
            wr_prev = wr; rd_prev = rd; hs2_prev = hs2;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] cmd, rg;
        int n, delay, r;
        rst_n = 1'b0; up_start = 1'b0; up_hs1 = 1'b0; up_dout = '0; sel = 1'b0;
        rd_delay = -1; rd_value = '0; tmo_armed = 1'b0;
        exp_wr = 1'b0; exp_rd = 1'b0; exp_addr = '0; exp_wdata = '0;
        wr_seen = 0; rd_seen = 0; last_addr = '0; last_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_a_outputs", {a_hs2, a_ack, a_wr, a_rd, a_din, a_addr, 4'h0}, 32'd0);
        check("rst_a_wdata", a_wdata, 32'd0);
        check("rst_b_outputs", {b_hs2, b_ack, b_wr, b_rd, b_din, b_addr, 4'h0}, 32'd0);
        check("rst_b_wdata", 32'(b_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed write, read, timeout, bad command, bad register on the 4-byte instance
        build(6, 8'd0, 8'd3, 8'd42, 8'd0, 8'd7, 8'd5);
        run_packet(-1, 32'h0);
        check("lit_write_addr", 32'(last_addr), 32'd3);
        check("lit_write_data", last_wdata, 32'h0507002A);
        expect_got(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        build(2, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0);
        run_packet(2, 32'h11223344);
        expect_got(5, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11);

        build(2, 8'd1, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0);
        run_packet(-1, 32'hDEADBEEF);
        expect_got(1, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00);

        build(1, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        run_packet(0, 32'h0);
        expect_got(1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);

        build(6, 8'd0, 8'd200, 8'd1, 8'd2, 8'd3, 8'd4);
        run_packet(0, 32'h0);
        expect_got(1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);

        build(2, 8'd1, 8'd63, 8'd0, 8'd0, 8'd0, 8'd0);
        run_packet(0, 32'hCAFEF00D);
        expect_got(5, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA);

        // Abort after the second data byte of a write
        build(4, 8'd0, 8'd3, 8'h11, 8'h22, 8'd0, 8'd0);
        exp_wr = 1'b0; exp_rd = 1'b0; wr_seen = 0; rd_seen = 0; tmo_armed = 1'b0;
        up_start = 1'b1;
        repeat (SS_A + 2) @(negedge clk);
        foreach (pkt[i]) send_byte(pkt[i]);
        up_start = 1'b0;
        repeat (SS_A + 4) begin
            @(negedge clk);
            check("abort_ack", 32'(ack), 32'd0);
        end
        check("abort_hs2", 32'(hs2), 32'd0);
        check("abort_no_write", 32'(wr_seen), 32'd0);
        build(6, 8'd0, 8'd10, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        run_packet(-1, 32'h0);
        check("post_abort_write", last_wdata, 32'hD4C3B2A1);

        // Parametric instance: 2 data bytes, 3 sync stages
        sel = 1'b1;
        repeat (2) @(negedge clk);
        build(4, 8'd0, 8'd12, 8'hEF, 8'hBE, 8'd0, 8'd0);
        run_packet(-1, 32'h0);
        check("lit_b_write_data", last_wdata, 32'h0000BEEF);
        check("lit_b_write_addr", 32'(last_addr), 32'd12);

        // Asynchronous reset while the block holds uP_handshake_2 high mid-packet
        build(2, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0);
        exp_wr = 1'b0; exp_rd = 1'b0; wr_seen = 0; rd_seen = 0; tmo_armed = 1'b0;
        up_start = 1'b1;
        repeat (SS_B + 2) @(negedge clk);
        foreach (pkt[i]) send_byte(pkt[i]);
        up_dout = 8'h5A;
        up_hs1 = 1'b1;
        n = 0;
        while (hs2 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_hs2", 32'(hs2), 32'd1);
        check("pre_reset_addr", 32'(addr), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {hs2, ack, wr, rd, din, addr, 4'h0}, 32'd0);
        check("async_reset_wdata", wdata, 32'd0);
        up_hs1 = 1'b0;
        up_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Randomised packets on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            repeat (2) @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                r = $urandom_range(0, 9);
                cmd = (r < 4) ? 8'd0 : (r < 8) ? 8'd1 : 8'($urandom_range(2, 255));
                rg = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 63));
                pkt.delete();
                pkt.push_back(cmd);
                if (cmd <= 8'd1) pkt.push_back(rg);
                if (cmd == 8'd0) for (int k = 0; k < db_of(); k++) pkt.push_back(8'($urandom_range(0, 255)));
                delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
                run_packet(delay, $urandom());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
